reg_file_ctrl: RTL and testbench
================================

// Module: reg_file_ctrl
// PURPOSE
//  Byte-command sequencer for the 8x16 register file, sitting between the RX deserializer and the TX serializer.
//  Decodes write frames (WR_CMD,addr,lo,hi) and read frames (RD_CMD,addr) from the RX byte stream.
//  Drives the register file's one-cycle WrEn/RdEn strobes, captures RdData on RdData_Valid and returns it as two TX bytes.
//  It is the register file's only master.
// PARAMETERS
//  DATA_WIDTH    16     register width; fixed at 16 (two-byte payload)
//  ADDR_WIDTH    4      register-file address width
//  DEPTH         8      number of implemented registers
//  WR_CMD        8'hAA  write-frame opcode
//  RD_CMD        8'hBB  read-frame opcode
//  ERR_CODE      8'hEE  single-byte error response
//  RD_TIMEOUT    3      max cycles in RD_WAIT before error response
// PORTS
//  CLK           in   1   system clock, all logic on rising edge
//  RST           in   1   asynchronous active-low reset
//  RX_P_DATA     in   8   received byte
//  RX_D_VLD      in   1   one-cycle strobe, RX_P_DATA valid
//  WrData        out  16  register-file write data
//  Address       out  4   register-file address
//  WrEn          out  1   register-file write strobe
//  RdEn          out  1   register-file read strobe
//  RdData        in   16  register-file read data
//  RdData_Valid  in   1   register-file read-data valid
//  TX_P_DATA     out  8   byte to transmit
//  TX_D_VLD      out  1   one-cycle strobe, TX_P_DATA valid
//  TX_BUSY       in   1   serializer busy; no TX_D_VLD while high
//  CTRL_BUSY     out  1   high whenever state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, capture registers 0. Reset mid-frame aborts; no strobe issued afterwards.
//  - All outputs registered. WrEn, RdEn and TX_D_VLD are exactly one cycle wide.
//  - States: IDLE, WR_ADDR, WR_DLO, WR_DHI, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_LO, TX_GAP, TX_HI, TX_ERR.
//  - IDLE: RX_D_VLD with WR_CMD -> WR_ADDR; with RD_CMD -> RD_ADDR; any other byte is discarded.
//  - WR_ADDR/WR_DLO/WR_DHI: each advances only on RX_D_VLD. The frame latches addr[ADDR_WIDTH-1:0], lo, then hi.
//  - WR_EXEC: entered in the cycle after the hi byte. WrEn=1, WrData={hi,lo}, Address=addr for 1 cycle, then IDLE.
//  - RD_ADDR: on the addr byte -> RD_EXEC. In RD_EXEC, RdEn=1 and Address=addr for 1 cycle -> RD_WAIT.
//  - RD_WAIT: RdData_Valid=1 captures RdData -> TX_LO.
//    No RdData_Valid within RD_TIMEOUT cycles -> TX_ERR.
//  - TX_LO/TX_HI: wait while TX_BUSY=1. Once TX_BUSY=0, pulse TX_D_VLD with RdData[7:0] (TX_LO) or RdData[15:8] (TX_HI).
//    TX_LO exits to TX_GAP; TX_HI exits to IDLE.
//  - TX_GAP: one cycle; TX_BUSY is ignored there (serializer raises it the cycle after the strobe); then TX_HI.
//  - TX_ERR: wait for TX_BUSY=0, send ERR_CODE once, then IDLE.
//  - RX_D_VLD in RD_EXEC..TX_ERR or WR_EXEC: byte dropped, no queueing. A new frame needs IDLE.
//  - RX bytes are never matched against opcodes mid-frame: 0xAA as an address or data byte is data.
//  - WrEn and RdEn are never high together. Address holds its last value between frames.
// CONFIGURATION
//  REGCTRL_ADDR_CHECK_EN defined:
//   - Write frame with address byte >= DEPTH: remaining bytes are still consumed, WrEn is suppressed, then IDLE. No TX response.
//   - Read frame with address byte >= DEPTH: RdEn is not asserted; goes to TX_ERR and sends ERR_CODE.
//  REGCTRL_ADDR_CHECK_EN undefined:
//   - Address byte truncated to [ADDR_WIDTH-1:0] and passed through unchecked. ERR_CODE is produced only by read timeout.
// TESTING
//  1 Write: RX AA,02,34,12 -> next cycle WrEn=1, Address=2, WrData=16'h1234, one cycle only; CTRL_BUSY=0 after.
//  2 Read-back: after 1, RX BB,02 -> RdEn 1 cycle, Address=2. TX bytes 34 then 12, each TX_D_VLD 1 cycle.
//    Hold TX_BUSY=1 for 10 cycles after each strobe; the next byte must wait.
//  3 Junk/drop: RX 55 in IDLE ignored. RX BB,01, then AA during TX_LO: no WrEn, two read bytes only.
//  4 Timeout: RX BB,03 with RdData_Valid tied 0 -> after 3 cycles TX_P_DATA=EE, single TX_D_VLD.
//  5 Reset mid-frame: RX AA,01,FF, then RST low 1 cycle, then RX 77 -> no WrEn; all outputs 0 during reset.
//  6 Macro on: RX AA,09,01,00 -> no WrEn; RX BB,0A -> no RdEn, TX EE.
//    Macro off: RX BB,09 -> RdEn with Address=9.

Source files
------------

// File: rtl/reg_file_ctrl.sv
// Byte-command sequencer: decodes RX write/read frames, drives the 8x16 register file and returns read data over TX.
// Optional build macro REGCTRL_ADDR_CHECK_EN rejects frame addresses >= DEPTH.
module reg_file_ctrl #(
  parameter int         DATA_WIDTH = 16,
  parameter int         ADDR_WIDTH = 4,
  parameter int         DEPTH      = 8,
  parameter logic [7:0] WR_CMD     = 8'hAA,
  parameter logic [7:0] RD_CMD     = 8'hBB,
  parameter logic [7:0] ERR_CODE   = 8'hEE,
  parameter int         RD_TIMEOUT = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [7:0]            RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [DATA_WIDTH-1:0] WrData,
  output logic [ADDR_WIDTH-1:0] Address,
  output logic                  WrEn,
  output logic                  RdEn,
  input  logic [DATA_WIDTH-1:0] RdData,
  input  logic                  RdData_Valid,
  output logic [7:0]            TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_BUSY,
  output logic                  CTRL_BUSY
);

  localparam int TO_W = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;

`ifdef REGCTRL_ADDR_CHECK_EN
  localparam bit ADDR_CHECK = 1'b1;
`else
  localparam bit ADDR_CHECK = 1'b0;
`endif

  typedef enum logic [3:0] {
    IDLE, WR_ADDR, WR_DLO, WR_DHI, WR_EXEC,
    RD_ADDR, RD_EXEC, RD_WAIT,
    TX_LO, TX_GAP, TX_HI, TX_ERR
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q, addr_q_nxt;
  logic [7:0]            lo_q, lo_q_nxt;
  logic                  bad_q, bad_q_nxt;
  logic [DATA_WIDTH-1:0] rd_q, rd_q_nxt;
  logic [TO_W-1:0]       to_cnt, to_cnt_nxt;

  logic [DATA_WIDTH-1:0] wr_data_nxt;
  logic [ADDR_WIDTH-1:0] address_nxt;
  logic                  wr_en_nxt, rd_en_nxt, tx_vld_nxt;
  logic [7:0]            tx_data_nxt;

  logic [ADDR_WIDTH-1:0] rx_addr;
  logic                  addr_bad;
  logic                  timeout;

  // Address bytes are truncated; the range check only has effect when the macro is defined.
  assign rx_addr  = RX_P_DATA[ADDR_WIDTH-1:0];
  assign addr_bad = ADDR_CHECK && (32'(RX_P_DATA) >= 32'(DEPTH));
  assign timeout  = (to_cnt == TO_W'(RD_TIMEOUT - 1));

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (RX_D_VLD && (RX_P_DATA == WR_CMD))      state_nxt = WR_ADDR;
        else if (RX_D_VLD && (RX_P_DATA == RD_CMD)) state_nxt = RD_ADDR;
      end
      WR_ADDR: if (RX_D_VLD) state_nxt = WR_DLO;
      WR_DLO:  if (RX_D_VLD) state_nxt = WR_DHI;
      WR_DHI:  if (RX_D_VLD) state_nxt = WR_EXEC;
      WR_EXEC: state_nxt = IDLE;
      RD_ADDR: if (RX_D_VLD) state_nxt = addr_bad ? TX_ERR : RD_EXEC;
      RD_EXEC: state_nxt = RD_WAIT;
      RD_WAIT: begin
        if (RdData_Valid) state_nxt = TX_LO;
        else if (timeout) state_nxt = TX_ERR;
      end
      TX_LO:   if (!TX_BUSY) state_nxt = TX_GAP;
      // The serializer only raises TX_BUSY the cycle after a strobe, so this cycle skips the check.
      TX_GAP:  state_nxt = TX_HI;
      TX_HI:   if (!TX_BUSY) state_nxt = IDLE;
      TX_ERR:  if (!TX_BUSY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    addr_q_nxt  = addr_q;
    lo_q_nxt    = lo_q;
    bad_q_nxt   = bad_q;
    rd_q_nxt    = rd_q;
    to_cnt_nxt  = to_cnt;
    wr_data_nxt = WrData;
    address_nxt = Address;
    tx_data_nxt = TX_P_DATA;
    wr_en_nxt   = 1'b0;
    rd_en_nxt   = 1'b0;
    tx_vld_nxt  = 1'b0;
    case (state)
      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_q_nxt = rx_addr;
          bad_q_nxt  = addr_bad;
        end
      end
      WR_DLO: if (RX_D_VLD) lo_q_nxt = RX_P_DATA;
      WR_DHI: begin
        if (RX_D_VLD && !bad_q) begin
          wr_en_nxt   = 1'b1;
          wr_data_nxt = DATA_WIDTH'({RX_P_DATA, lo_q});
          address_nxt = addr_q;
        end
      end
      RD_ADDR: begin
        if (RX_D_VLD) begin
          addr_q_nxt = rx_addr;
          if (!addr_bad) begin
            rd_en_nxt   = 1'b1;
            address_nxt = rx_addr;
          end
        end
      end
      RD_EXEC: to_cnt_nxt = '0;
      RD_WAIT: begin
        if (RdData_Valid) rd_q_nxt = RdData;
        else              to_cnt_nxt = to_cnt + TO_W'(1);
      end
      TX_LO: begin
        if (!TX_BUSY) begin
          tx_vld_nxt  = 1'b1;
          tx_data_nxt = rd_q[7:0];
        end
      end
      TX_HI: begin
        if (!TX_BUSY) begin
          tx_vld_nxt  = 1'b1;
          tx_data_nxt = rd_q[DATA_WIDTH-1 -: 8];
        end
      end
      TX_ERR: begin
        if (!TX_BUSY) begin
          tx_vld_nxt  = 1'b1;
          tx_data_nxt = ERR_CODE;
        end
      end
      default: ;
    endcase
  end

  // Outputs are registered from next-state values so strobes line up with their state cycle.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      addr_q    <= '0;
      lo_q      <= '0;
      bad_q     <= 1'b0;
      rd_q      <= '0;
      to_cnt    <= '0;
      WrData    <= '0;
      Address   <= '0;
      WrEn      <= 1'b0;
      RdEn      <= 1'b0;
      TX_P_DATA <= '0;
      TX_D_VLD  <= 1'b0;
      CTRL_BUSY <= 1'b0;
    end else begin
      addr_q    <= addr_q_nxt;
      lo_q      <= lo_q_nxt;
      bad_q     <= bad_q_nxt;
      rd_q      <= rd_q_nxt;
      to_cnt    <= to_cnt_nxt;
      WrData    <= wr_data_nxt;
      Address   <= address_nxt;
      WrEn      <= wr_en_nxt;
      RdEn      <= rd_en_nxt;
      TX_P_DATA <= tx_data_nxt;
      TX_D_VLD  <= tx_vld_nxt;
      CTRL_BUSY <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Testbench for reg_file_ctrl: frame vectors with hand-computed results plus reset and byte-drop sequences.
// Expectations follow the REGCTRL_ADDR_CHECK_EN build setting.
module tb_reg_file_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = 8'h00;
  logic        RX_D_VLD = 1'b0;
  logic [15:0] WrData;
  logic [3:0]  Address;
  logic        WrEn, RdEn;
  logic [15:0] RdData = 16'h0000;
  logic        RdData_Valid = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_BUSY = 1'b0;
  logic        CTRL_BUSY;

  reg_file_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .WrData(WrData), .Address(Address), .WrEn(WrEn), .RdEn(RdEn),
    .RdData(RdData), .RdData_Valid(RdData_Valid),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY), .CTRL_BUSY(CTRL_BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int          n;
    logic [31:0] frame;
    int          busy;
    bit          no_resp;
    int          exp_wr;
    logic [3:0]  exp_waddr;
    logic [15:0] exp_wdata;
    int          exp_rd;
    logic [3:0]  exp_raddr;
    int          exp_tx;
    logic [7:0]  exp_t0;
    logic [7:0]  exp_t1;
    int          exp_lat;
    int          exp_gap;
  } vec_t;

  vec_t vq[$];
  vec_t v;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [15:0] mem [16];
  bit          pend = 1'b0;
  logic [3:0]  pend_addr = 4'h0;
  int          busy_len = 0;
  int          busy_cnt = 0;
  bit          busy_force = 1'b0;
  bit          no_resp = 1'b0;

  int          wr_cnt = 0, rd_cnt = 0, width_err = 0, both_err = 0, rd_cyc = 0;
  logic [3:0]  wr_addr = 4'h0, rd_addr = 4'h0;
  logic [15:0] wr_data = 16'h0000;
  logic [7:0]  tx_q[$];
  int          txc_q[$];
  bit          wr_prev = 1'b0, rd_prev = 1'b0, tx_prev = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Register-file and serializer stand-ins: read data one cycle after RdEn, TX_BUSY for busy_len cycles.
  always @(negedge CLK) begin
    RdData_Valid = pend;
    if (pend) RdData = mem[pend_addr];
    pend      = RdEn && !no_resp;
    pend_addr = Address;
    if (WrEn) mem[Address] = WrData;
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (TX_D_VLD && busy_len > 0) busy_cnt = busy_len;
    TX_BUSY = busy_force || (busy_cnt > 0);
  end

  always @(negedge CLK) begin
    if (RST) begin
      if (WrEn) begin wr_cnt++; wr_addr = Address; wr_data = WrData; end
      if (RdEn) begin rd_cnt++; rd_addr = Address; rd_cyc = cyc; end
      if (TX_D_VLD) begin tx_q.push_back(TX_P_DATA); txc_q.push_back(cyc); end
      if ((WrEn && wr_prev) || (RdEn && rd_prev) || (TX_D_VLD && tx_prev)) width_err++;
      if (WrEn && RdEn) both_err++;
    end
    wr_prev = WrEn;
    rd_prev = RdEn;
    tx_prev = TX_D_VLD;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge CLK);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    @(negedge CLK);
    RX_D_VLD  = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((CTRL_BUSY || TX_BUSY) && n < 200);
    if (n >= 200) begin
      checks++;
      fails++;
      $display("FAIL %s_idle_timeout: got busy expected idle within 200 cycles", nm);
    end
    repeat (3) @(negedge CLK);
  endtask

  task automatic clear_mon();
    wr_cnt = 0;
    rd_cnt = 0;
    tx_q.delete();
    txc_q.delete();
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] fr, input int busy, input bit nr,
                              input int ewr, input logic [3:0] ewa, input logic [15:0] ewd,
                              input int erd, input logic [3:0] era,
                              input int etx, input logic [7:0] t0, input logic [7:0] t1,
                              input int lat, input int gap);
    vec_t r;
    r.n = n; r.frame = fr; r.busy = busy; r.no_resp = nr;
    r.exp_wr = ewr; r.exp_waddr = ewa; r.exp_wdata = ewd;
    r.exp_rd = erd; r.exp_raddr = era;
    r.exp_tx = etx; r.exp_t0 = t0; r.exp_t1 = t1;
    r.exp_lat = lat; r.exp_gap = gap;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = {4'hC, 4'(i), 4'h5, 4'(i)};

    //                n  frame         busy nr  wr addr data      rd addr tx t0     t1     lat gap
    vq.push_back(mk(4, 32'hAA023412, 0,   0,  1, 4'h2, 16'h1234, 0, 4'h0, 0, 8'h00, 8'h00, 0, 0));
    vq.push_back(mk(2, 32'hBB020000, 10,  0,  0, 4'h0, 16'h0000, 1, 4'h2, 2, 8'h34, 8'h12, 3, 11));
    vq.push_back(mk(1, 32'h55000000, 0,   0,  0, 4'h0, 16'h0000, 0, 4'h0, 0, 8'h00, 8'h00, 0, 0));
    vq.push_back(mk(4, 32'hAA05AAAA, 0,   0,  1, 4'h5, 16'hAAAA, 0, 4'h0, 0, 8'h00, 8'h00, 0, 0));
    vq.push_back(mk(4, 32'hAA07CDAB, 0,   0,  1, 4'h7, 16'hABCD, 0, 4'h0, 0, 8'h00, 8'h00, 0, 0));
    vq.push_back(mk(2, 32'hBB050000, 0,   0,  0, 4'h0, 16'h0000, 1, 4'h5, 2, 8'hAA, 8'hAA, 3, 2));
    vq.push_back(mk(2, 32'hBB070000, 0,   0,  0, 4'h0, 16'h0000, 1, 4'h7, 2, 8'hCD, 8'hAB, 3, 2));
`ifdef REGCTRL_ADDR_CHECK_EN
    vq.push_back(mk(4, 32'hAA090100, 0,   0,  0, 4'h0, 16'h0000, 0, 4'h0, 0, 8'h00, 8'h00, 0, 0));
    vq.push_back(mk(2, 32'hBB0A0000, 0,   0,  0, 4'h0, 16'h0000, 0, 4'h0, 1, 8'hEE, 8'h00, 0, 0));
`else
    vq.push_back(mk(4, 32'hAA090100, 0,   0,  1, 4'h9, 16'h0001, 0, 4'h0, 0, 8'h00, 8'h00, 0, 0));
    vq.push_back(mk(2, 32'hBB090000, 0,   0,  0, 4'h0, 16'h0000, 1, 4'h9, 2, 8'h01, 8'h00, 3, 2));
`endif
    vq.push_back(mk(2, 32'hBB030000, 0,   1,  0, 4'h0, 16'h0000, 1, 4'h3, 1, 8'hEE, 8'h00, 5, 0));

    #2 RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("reset_outputs", {WrData, Address, TX_P_DATA, WrEn, RdEn, TX_D_VLD, CTRL_BUSY}, 32'h0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      clear_mon();
      busy_len = v.busy;
      no_resp  = v.no_resp;
      for (int k = 0; k < v.n; k++) send_byte(v.frame[31-8*k -: 8]);
      wait_idle($sformatf("v%0d", i));
      check($sformatf("v%0d_wr_cnt", i), wr_cnt, v.exp_wr);
      if (v.exp_wr > 0) begin
        check($sformatf("v%0d_wr_addr", i), wr_addr, v.exp_waddr);
        check($sformatf("v%0d_wr_data", i), wr_data, v.exp_wdata);
      end
      check($sformatf("v%0d_rd_cnt", i), rd_cnt, v.exp_rd);
      if (v.exp_rd > 0) check($sformatf("v%0d_rd_addr", i), rd_addr, v.exp_raddr);
      check($sformatf("v%0d_tx_cnt", i), tx_q.size(), v.exp_tx);
      if (v.exp_tx > 0 && tx_q.size() > 0) begin
        check($sformatf("v%0d_tx0", i), tx_q[0], v.exp_t0);
        if (v.exp_rd > 0) check($sformatf("v%0d_latency", i), txc_q[0] - rd_cyc, v.exp_lat);
      end
      if (v.exp_tx > 1 && tx_q.size() > 1) begin
        check($sformatf("v%0d_tx1", i), tx_q[1], v.exp_t1);
        check($sformatf("v%0d_tx_gap", i), txc_q[1] - txc_q[0], v.exp_gap);
      end
    end
    no_resp  = 1'b0;
    busy_len = 0;

    // Bytes arriving while the reply is stalled are dropped, including a write opcode.
    clear_mon();
    busy_force = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h01);
    repeat (6) @(negedge CLK);
    check("drop_busy_held", CTRL_BUSY, 1);
    check("drop_no_tx_while_busy", tx_q.size(), 0);
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    busy_force = 1'b0;
    wait_idle("drop");
    check("drop_wr_cnt", wr_cnt, 0);
    check("drop_rd_cnt", rd_cnt, 1);
    check("drop_tx_cnt", tx_q.size(), 2);
    if (tx_q.size() > 1) begin
      check("drop_tx0", tx_q[0], 8'h51);
      check("drop_tx1", tx_q[1], 8'hC1);
    end

    // Reset in the middle of a write frame must abort it.
    clear_mon();
    send_byte(8'hAA);
    send_byte(8'h01);
    send_byte(8'hFF);
    check("rst_busy_before", CTRL_BUSY, 1);
    RST = 1'b0;
    #1;
    check("rst_mid_outputs", {WrData, Address, TX_P_DATA, WrEn, RdEn, TX_D_VLD, CTRL_BUSY}, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    send_byte(8'h77);
    wait_idle("rst");
    check("rst_no_wren", wr_cnt, 0);
    check("rst_idle", CTRL_BUSY, 0);

    check("pulse_width_err", width_err, 0);
    check("wr_rd_overlap", both_err, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
